demux_scan_ctrl: RTL
====================

# demux_scan_ctrl

Round-robin scheduler that shares the 3-to-7 active-low output demultiplexer among seven requesters. It drives the demux select code and enable, holding each grant for a programmable dwell time. It also provides a registered active-low one-hot grant vector that matches the demux outputs, for local use and checking. It sits directly upstream of the demux, between the request sources and the select/enable pins.

## Interface
- `DWELL`, default 8: maximum cycles a grant is held with enable high; legal range 1..255.
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  7: request per channel; `req[i]` asks for demux output i.
- `sel`  out 3: select code to the demux; `sel[2]` drives b0 (MSB), `sel[1]` drives b1, `sel[0]` drives b2.
- `en`   out 1: demux enable.
- `grant_n` out 7: active-low one-hot grant. `grant_n[i]` = 0 exactly when `en`=1 and `sel`=i.
- `busy` out 1: high while in GRANT or BLANK.
- `done` out 1: one-cycle pulse in the cycle after each grant ends.

## Operation
- States:
  - IDLE: `en`=0.
  - GRANT: `en`=1, dwell counter running.
  - BLANK: `en`=0, one cycle; exists only with the macro below.
- Round-robin pointer `last` (3 bits) records the most recently granted channel. Search order is `last`+1, `last`+2, … modulo 7, over channels 0..6 only.
- Code 7 (`sel`=3'b111) is never driven.
- IDLE → GRANT: when any `req` bit is high, grant the first requesting channel in search order. Load `sel`, set `last` to that channel, clear the dwell counter.
- GRANT ends when either:
  - the dwell counter reaches `DWELL`-1, or
  - `req[sel]` is sampled low (early release).
- On grant end, with the macro: go to BLANK, then after one cycle to GRANT (next channel) if any request is pending, else IDLE.
- On grant end, without the macro: go directly to GRANT with the next channel if any request is pending (`en` stays 1 and `sel` changes in the same edge), else IDLE.
- A channel whose grant just ended may be re-granted only if no other channel requests. If it is the sole requester, it is re-granted.
- The dwell counter width is ceil(log2(`DWELL`+1)). It resets to 0 on every new grant and never wraps.
- `done` pulses once per grant end, whether the end was due to dwell expiry or early release.
- Reset mid-grant: the state goes to IDLE, `en` drops in the next cycle, and no `done` pulse is generated.
- Reset values: `sel`=0, `en`=0, `grant_n`=7'b1111111, `busy`=0, `done`=0, `last`=6 (so the first search starts at channel 0), dwell counter=0.

## Timing
- All outputs are registered. There is no combinational path from `req` to any output.
- Grant latency: `req` sampled high at edge N while IDLE → `en`=1 and valid `sel` after edge N+1.
- Dwell: with `req` held high, `en` stays 1 for exactly `DWELL` consecutive cycles per grant.
- Early release: `req[sel]` sampled low at edge M → grant ends at edge M+1.
- `done` is high for the one cycle following the last GRANT cycle.
- `grant_n` and `sel` update on the same edge, so they are never inconsistent.
- Simultaneous rise of several `req` bits: exactly one grant, chosen in search order.
- Requests that arrive during a grant are only considered at grant end.

## Configuration
- `DEMUX_SCAN_BLANK_EN` defined: one BLANK cycle with `en`=0 and `grant_n`=all ones between consecutive grants. This prevents overlap of demux outputs during a select change.
- `DEMUX_SCAN_BLANK_EN` undefined: no BLANK state. Back-to-back grants keep `en` high across the select change, and the minimum grant-to-grant gap is zero cycles.

## Test plan
- Reset: assert `rst` for 2 cycles with `req`=7'h7F → `sel`=0, `en`=0, `grant_n`=7'h7F, `busy`=0. After release, first grant goes to channel 0.
- Single requester, `DWELL`=4: `req`=7'b0001000 held → `sel`=3 with `en`=1 for 4 cycles, then `done` pulse, then re-grant of channel 3. With the macro, one `en`=0 cycle appears between grants.
- Round robin: `req`=7'b1000101 held → grant order 0, 2, 6, 0, …. Verify `grant_n` equals 7'b1111110, 7'b1111011, 7'b0111111 in turn, and that `sel` never equals 7.
- Early release, `DWELL`=8: channel 5 granted, `req[5]` dropped after 2 grant cycles → `en` low (or next grant) at the following edge; `done` pulses once.
- Reset mid-grant: `rst` asserted during the 3rd dwell cycle → `en`=0 next cycle, no `done`, and the next grant after release starts from channel 0.
- Macro off, `req`=7'b0000011, `DWELL`=1 → `en` continuously 1 while `sel` alternates 0, 1, 0, 1 on every cycle.

Source files
------------

// File: rtl/demux_scan_ctrl.sv
// Round-robin scheduler sharing a 3-to-7 active-low demux among seven requesters.
// Define DEMUX_SCAN_BLANK_EN to insert one enable-low BLANK cycle between consecutive grants.
module demux_scan_ctrl #(
  parameter int DWELL = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_req,
  output logic [2:0] o_sel,
  output logic       o_en,
  output logic [6:0] o_grant_n,
  output logic       o_busy,
  output logic       o_done
);

  localparam int CntW = $clog2(DWELL + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DWELL - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StBlank} state_e;

  state_e          r_state, w_state_d;
  logic [6:0]      r_req;
  logic [2:0]      r_last, w_last_d;
  logic [2:0]      r_sel, w_sel_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            r_en, w_en_d;
  logic [6:0]      r_grant_n, w_grant_n_d;
  logic            r_busy, w_busy_d;
  logic            r_done, w_done_d;
  logic [2:0]      w_pick;
  logic            w_any;
  logic            w_end;
  logic            w_load;

  // Search last+1 .. last+6 first; last itself comes last so it wins only as sole requester.
  function automatic logic [2:0] f_pick(input logic [6:0] req, input logic [2:0] last);
    logic [2:0] pick;
    int         t;
    pick = 3'd0;
    for (int k = 7; k >= 1; k--) begin
      t = (int'(last) + k) % 7;
      if (req[t[2:0]]) pick = t[2:0];
    end
    return pick;
  endfunction

  assign w_pick = f_pick(r_req, r_last);
  assign w_any  = |r_req;
  assign w_end  = (r_cnt == CntLast) || !r_req[r_sel];

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    w_load    = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_any) begin
          w_state_d = StGrant;
          w_load    = 1'b1;
        end
      end
      StGrant: begin
        if (w_end) begin
`ifdef DEMUX_SCAN_BLANK_EN
          w_state_d = StBlank;
`else
          if (w_any) begin
            w_state_d = StGrant;
            w_load    = 1'b1;
          end else begin
            w_state_d = StIdle;
          end
`endif
        end
      end
      StBlank: begin
        if (w_any) begin
          w_state_d = StGrant;
          w_load    = 1'b1;
        end else begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Output logic: next values for the registered outputs
  always_comb begin
    w_sel_d  = r_sel;
    w_last_d = r_last;
    w_cnt_d  = r_cnt;
    if (w_load) begin
      w_sel_d  = w_pick;
      w_last_d = w_pick;
      w_cnt_d  = '0;
    end else if (r_state == StGrant && r_cnt != CntLast) begin
      w_cnt_d = r_cnt + CntW'(1);
    end
    w_en_d      = (w_state_d == StGrant);
    w_busy_d    = (w_state_d != StIdle);
    w_done_d    = (r_state == StGrant) && w_end;
    w_grant_n_d = w_en_d ? ~(7'd1 << w_sel_d) : 7'h7F;
  end

  // Request sampling and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_req     <= '0;
      r_last    <= 3'd6;
      r_sel     <= 3'd0;
      r_cnt     <= '0;
      r_en      <= 1'b0;
      r_grant_n <= 7'h7F;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_req     <= i_req;
      r_last    <= w_last_d;
      r_sel     <= w_sel_d;
      r_cnt     <= w_cnt_d;
      r_en      <= w_en_d;
      r_grant_n <= w_grant_n_d;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
    end
  end

  assign o_sel     = r_sel;
  assign o_en      = r_en;
  assign o_grant_n = r_grant_n;
  assign o_busy    = r_busy;
  assign o_done    = r_done;

endmodule
